// File: rtl/knn_group_gather_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : knn_group_gather_pkg
//  Description : Shared constants and types for the KNN group-gather block:
//                point/axis/delta widths, FSM state encoding, the number of
//                neighbours per triplet and a stage-index width helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package knn_group_gather_pkg;

  localparam int POINT_W = 24;           // packed {x,y,z}
  localparam int AXIS_W  = POINT_W / 3;  // unsigned axis coordinate
  localparam int DELTA_W = AXIS_W + 1;   // signed axis difference
  localparam int K_NUM   = 3;            // neighbours per triplet

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  // Stage index width; a single-stage configuration still needs one bit.
  function automatic int stage_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/knn_group_gather_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : knn_group_gather_if
//  Description : Output beat stream of the group-gather block, one relative
//                neighbour point per beat with valid/ready handshake.
//  Ports       : grp_data  - {dx,dy,dz}, two's complement per axis
//                grp_stage - stage index of the beat
//                grp_k     - neighbour index 0..2
//                grp_last  - final beat of the centre point
//                grp_vld   - beat valid
//                grp_ready - downstream accepts the beat
//  Revision    : 1.0 - initial release
// ============================================================================
interface knn_group_gather_if import knn_group_gather_pkg::*; #(
  parameter int addr_W    = POINT_W,
  parameter int stage_num = 8
) ();

  localparam int DW = addr_W / 3 + 1;
  localparam int SW = stage_width(stage_num);

  logic [3*DW-1:0] grp_data;
  logic [SW-1:0]   grp_stage;
  logic [1:0]      grp_k;
  logic            grp_last;
  logic            grp_vld;
  logic            grp_ready;

  modport master (
    output grp_data, grp_stage, grp_k, grp_last, grp_vld,
    input  grp_ready
  );

  modport slave (
    input  grp_data, grp_stage, grp_k, grp_last, grp_vld,
    output grp_ready
  );

endinterface
`default_nettype wire

// File: rtl/knn_group_gather_triplet_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : triplet_fifo
//  Description : Synchronous FIFO holding neighbour triplets. The head entry
//                is presented combinationally. When full, a push is accepted
//                only if a pop happens in the same cycle.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                push, din    - write request and data
//                pop, dout    - read request and head data
//                full, empty  - occupancy flags
//                count        - number of stored entries
//  Revision    : 1.0 - initial release
// ============================================================================
module triplet_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       push,
  input  wire logic [WIDTH-1:0]           din,
  input  wire logic                       pop,
  output logic      [WIDTH-1:0]           dout,
  output logic                            full,
  output logic                            empty,
  output logic      [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push writes into.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/knn_group_gather.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : knn_group_gather
//  Description : Collects the nearest-neighbour triplets produced for one
//                centre point, buffers them and emits each neighbour as a
//                beat holding its offset from the centre point.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                cp, cp_vld        - centre point and its strobe
//                nb_0..nb_2        - neighbour triplet
//                nb_flag           - triplet strobe
//                cp_finish         - end of the centre point's triplets
//                grp (master)      - output beat stream
//                overflow          - sticky: a triplet was dropped
//                busy              - block is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module knn_group_gather import knn_group_gather_pkg::*; #(
  parameter int addr_W     = POINT_W,
  parameter int stage_num  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [addr_W-1:0] cp,
  input  wire logic              cp_vld,
  input  wire logic [addr_W-1:0] nb_0,
  input  wire logic [addr_W-1:0] nb_1,
  input  wire logic [addr_W-1:0] nb_2,
  input  wire logic              nb_flag,
  input  wire logic              cp_finish,
  knn_group_gather_if.master     grp,
  output logic                   overflow,
  output logic                   busy
);

  localparam int AW = addr_W / 3;
  localparam int DW = AW + 1;
  localparam int SW = stage_width(stage_num);
  localparam int EW = 3 * addr_W + SW;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(stage_num - 1);
  localparam logic [1:0]    K_LAST     = 2'(K_NUM - 1);

  state_t            state;
  logic [addr_W-1:0] cp_reg;
  logic [SW-1:0]     stage_cnt;
  logic [1:0]        k;

  logic              push_req;
  logic              push_accept;
  logic [EW-1:0]     head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  logic [addr_W-1:0] head_nb0;
  logic [addr_W-1:0] head_nb1;
  logic [addr_W-1:0] head_nb2;
  logic [SW-1:0]     head_stage;
  logic [addr_W-1:0] sel_nb;
  logic [3*DW-1:0]   delta;

  logic              vld;
  logic              hs;
  logic              beat_done;
  logic              last;

  // --------------------------------------------------------------------------
  // Triplet buffer: entry = {nb_0, nb_1, nb_2, stage}
  // --------------------------------------------------------------------------
  assign push_req    = (state == COLLECT) & nb_flag;
  assign push_accept = push_req & (~fifo_full | beat_done);

  triplet_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   ({nb_0, nb_1, nb_2, stage_cnt}),
    .pop   (beat_done),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_nb0   = head[EW-1 -: addr_W];
  assign head_nb1   = head[EW-1-addr_W -: addr_W];
  assign head_nb2   = head[SW +: addr_W];
  assign head_stage = head[SW-1:0];

  // --------------------------------------------------------------------------
  // Serialiser and subtractor
  // --------------------------------------------------------------------------
  always_comb begin
    case (k)
      2'd0:    sel_nb = head_nb0;
      2'd1:    sel_nb = head_nb1;
      default: sel_nb = head_nb2;
    endcase
  end

  // Axis 0 is z (lowest bits), so the result packs as {dx,dy,dz}.
  for (genvar a = 0; a < 3; a++) begin : g_axis
    assign delta[a*DW +: DW] = {1'b0, sel_nb[a*AW +: AW]} - {1'b0, cp_reg[a*AW +: AW]};
  end

  // Reset forces the stream quiet even before the first reset edge clears
  // the buffer, and keeps unwritten buffer contents off the bus.
  assign vld       = (fifo_count != '0) & ~rst;
  assign hs        = vld & grp.grp_ready;
  assign beat_done = hs & (k == K_LAST);
  assign last      = vld & (k == K_LAST) & (head_stage == LAST_STAGE) &
                     ((state == FLUSH) | ((state == COLLECT) & cp_finish));

  assign grp.grp_vld   = vld;
  assign grp.grp_data  = vld ? delta      : '0;
  assign grp.grp_stage = vld ? head_stage : '0;
  assign grp.grp_k     = vld ? k          : '0;
  assign grp.grp_last  = last;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cp_reg    <= '0;
      stage_cnt <= '0;
      k         <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (hs) k <= (k == K_LAST) ? 2'd0 : k + 2'd1;

      if (push_req & fifo_full & ~beat_done) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (cp_vld) begin
            state     <= COLLECT;
            busy      <= 1'b1;
            cp_reg    <= cp;
            stage_cnt <= '0;
          end
        end

        COLLECT: begin
          // Stage index advances even for dropped triplets.
          if (push_req && stage_cnt != LAST_STAGE) stage_cnt <= stage_cnt + 1'b1;
          if (cp_finish) begin
            // Nothing left to send, or the final beat leaves right now.
            if ((fifo_empty & ~push_accept) | (last & hs)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= FLUSH;
            end
          end
        end

        FLUSH: begin
          // An empty buffer also ends the flush, so a centre point whose
          // final-stage triplet was dropped cannot stall the block.
          if ((last & hs) | fifo_empty) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_knn_group_gather.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_knn_group_gather
//  Description : Self-checking bench for knn_group_gather: directed vectors,
//                multi-cycle corner sequences and randomized runs compared
//                against a queue-based reference model every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_knn_group_gather;
  import knn_group_gather_pkg::*;

  localparam int SN = 8;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] cp = '0, nb_0 = '0, nb_1 = '0, nb_2 = '0;
  logic        cp_vld = 1'b0, nb_flag = 1'b0, cp_finish = 1'b0;
  logic        overflow, busy;

  knn_group_gather_if #(.addr_W(24), .stage_num(SN)) gif ();

  knn_group_gather #(.addr_W(24), .stage_num(SN), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .rst       (rst),
    .cp        (cp),
    .cp_vld    (cp_vld),
    .nb_0      (nb_0),
    .nb_1      (nb_1),
    .nb_2      (nb_2),
    .nb_flag   (nb_flag),
    .cp_finish (cp_finish),
    .grp       (gif),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int beats = 0;
  int lasts = 0;
  int ready_mode = 0;  // 0 hold, 1 toggle every cycle, 2 random

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [23:0] n0;
    logic [23:0] n1;
    logic [23:0] n2;
    logic [7:0]  stage;
  } trip_t;

  trip_t       mq[$];
  bit          m_col = 0, m_fl = 0, m_ovf = 0;
  logic [23:0] m_cp = '0;
  int          m_stage = 0, m_k = 0;

  function automatic logic [8:0] dlt(input logic [7:0] a, input logic [7:0] b);
    int d;
    d = int'(a) - int'(b);
    return 9'(d);
  endfunction

  function automatic logic [26:0] rel(input logic [23:0] p, input logic [23:0] c);
    return {dlt(p[23:16], c[23:16]), dlt(p[15:8], c[15:8]), dlt(p[7:0], c[7:0])};
  endfunction

  logic        p_stall = 1'b0;
  logic [31:0] p_fields = '0;

  always @(negedge clk) begin
    bit          mv, ml, hs, pop, acc, empty0;
    trip_t       h;
    logic [23:0] nb;

    mv = !rst && mq.size() > 0;
    ml = 0;
    chk("grp_vld", gif.grp_vld, mv);
    chk("busy", busy, m_col || m_fl);
    chk("overflow", overflow, m_ovf);
    if (mv) begin
      h  = mq[0];
      nb = (m_k == 0) ? h.n0 : (m_k == 1) ? h.n1 : h.n2;
      ml = (m_k == 2) && (int'(h.stage) == SN - 1) && (m_fl || (m_col && cp_finish));
      chk("grp_data", gif.grp_data, rel(nb, m_cp));
      chk("grp_stage", gif.grp_stage, h.stage);
      chk("grp_k", gif.grp_k, m_k);
      chk("grp_last", gif.grp_last, ml);
    end
    if (p_stall && gif.grp_vld)
      chk("stall_stable", {gif.grp_data, gif.grp_stage, gif.grp_k}, p_fields);
    p_stall  = gif.grp_vld && !gif.grp_ready && !rst;
    p_fields = {gif.grp_data, gif.grp_stage, gif.grp_k};
    if (gif.grp_vld && gif.grp_ready) begin
      beats++;
      if (gif.grp_last) lasts++;
    end

    if (rst) begin
      mq.delete();
      m_col = 0; m_fl = 0; m_ovf = 0; m_k = 0; m_stage = 0; m_cp = '0;
    end else begin
      hs     = mv && gif.grp_ready;
      pop    = hs && m_k == 2;
      empty0 = mq.size() == 0;
      acc    = 0;
      if (m_col && nb_flag) begin
        if (mq.size() < FD || pop) acc = 1;
        else m_ovf = 1;
      end
      if (hs) m_k = (m_k == 2) ? 0 : m_k + 1;
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back('{n0: nb_0, n1: nb_1, n2: nb_2, stage: 8'(m_stage)});
      if (m_col && nb_flag && m_stage < SN - 1) m_stage++;
      if (!m_col && !m_fl) begin
        if (cp_vld) begin m_col = 1; m_cp = cp; m_stage = 0; end
      end else if (m_col) begin
        if (cp_finish) begin
          m_col = 0;
          m_fl  = !((empty0 && !acc) || (ml && hs));
        end
      end else if ((ml && hs) || empty0) begin
        m_fl = 0;
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic tick();
    @(posedge clk);
    #1;
    if (ready_mode == 1) gif.grp_ready = ~gif.grp_ready;
    else if (ready_mode == 2) gif.grp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic start_cp(input logic [23:0] c);
    cp = c; cp_vld = 1'b1; tick(); cp_vld = 1'b0;
  endtask

  task automatic push_trip(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    nb_0 = a; nb_1 = b; nb_2 = c; nb_flag = 1'b1; tick(); nb_flag = 1'b0;
  endtask

  task automatic push_rand();
    push_trip(24'($urandom), 24'($urandom), 24'($urandom));
  endtask

  task automatic finish_cp();
    cp_finish = 1'b1; tick(); cp_finish = 1'b0;
  endtask

  task automatic wait_novld(input int budget);
    int n = 0;
    while (gif.grp_vld && n < budget) begin tick(); n++; end
    chk("drain_timeout", n >= budget, 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || gif.grp_vld) && n < budget) begin tick(); n++; end
    chk("idle_timeout", n >= budget, 0);
  endtask

  typedef struct {
    logic [23:0] c, n0, n1, n2;
    logic [26:0] e0, e1, e2;
  } vec_t;

  vec_t vt[4];

  initial begin
    int b0, l0;
    logic [26:0] ex;

    vt[0] = '{24'h0A141E, 24'h0B131E, 24'h0A141E, 24'h00FFFF,
              {9'h001, 9'h1FF, 9'h000}, 27'h0, {9'h1F6, 9'h0EB, 9'h0E1}};
    vt[1] = '{24'h000000, 24'hFFFFFF, 24'h010203, 24'h000000,
              {9'h0FF, 9'h0FF, 9'h0FF}, {9'h001, 9'h002, 9'h003}, 27'h0};
    vt[2] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'hFE00FF,
              {9'h101, 9'h101, 9'h101}, 27'h0, {9'h1FF, 9'h101, 9'h000}};
    vt[3] = '{24'h808080, 24'h7F817F, 24'h00FF80, 24'hFF0080,
              {9'h1FF, 9'h001, 9'h1FF}, {9'h180, 9'h07F, 9'h000}, {9'h07F, 9'h180, 9'h000}};

    gif.grp_ready = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_vld", gif.grp_vld, 0);
    chk("rst_data", gif.grp_data, 0);
    chk("rst_stage", gif.grp_stage, 0);
    chk("rst_k", gif.grp_k, 0);
    chk("rst_last", gif.grp_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    tick();

    // Directed single-triplet vectors; finishing on an empty buffer idles at once
    gif.grp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_cp(vt[i].c);
      push_trip(vt[i].n0, vt[i].n1, vt[i].n2);
      for (int kk = 0; kk < 3; kk++) begin
        ex = (kk == 0) ? vt[i].e0 : (kk == 1) ? vt[i].e1 : vt[i].e2;
        chk("vec_vld", gif.grp_vld, 1);
        chk("vec_data", gif.grp_data, ex);
        chk("vec_k", gif.grp_k, kk);
        chk("vec_stage", gif.grp_stage, 0);
        chk("vec_last", gif.grp_last, 0);
        tick();
      end
      finish_cp();
      chk("vec_idle", busy, 0);
    end

    // Full 8-stage run, triplets 20 cycles apart
    do_reset();
    b0 = beats; l0 = lasts;
    start_cp(24'($urandom));
    for (int s = 0; s < SN; s++) begin
      push_rand();
      if (s < SN - 1) repeat (19) tick();
    end
    finish_cp();
    wait_idle(100);
    chk("full_beats", beats - b0, 24);
    chk("full_lasts", lasts - l0, 1);
    chk("full_ovf", overflow, 0);

    // Overflow: five triplets into a four-deep buffer under backpressure
    do_reset();
    gif.grp_ready = 1'b0;
    start_cp(24'($urandom));
    repeat (5) push_rand();
    chk("ovf_set", overflow, 1);
    b0 = beats;
    gif.grp_ready = 1'b1;
    wait_novld(100);
    chk("ovf_beats", beats - b0, 12);
    finish_cp();
    wait_idle(50);
    chk("ovf_sticky", overflow, 1);

    // Backpressure toggling every cycle
    do_reset();
    b0 = beats; l0 = lasts;
    ready_mode = 1;
    start_cp(24'($urandom));
    for (int s = 0; s < SN; s++) begin
      push_rand();
      if (s < SN - 1) repeat (5) tick();
    end
    finish_cp();
    wait_idle(200);
    ready_mode = 0;
    chk("bp_beats", beats - b0, 24);
    chk("bp_lasts", lasts - l0, 1);
    chk("bp_ovf", overflow, 0);

    // Reset with two buffered triplets
    gif.grp_ready = 1'b0;
    start_cp(24'($urandom));
    push_rand(); push_rand();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_vld", gif.grp_vld, 0);
    chk("mid_rst_busy", busy, 0);
    gif.grp_ready = 1'b1;
    repeat (3) tick();
    chk("mid_rst_quiet", gif.grp_vld, 0);
    start_cp(24'($urandom));
    push_rand();
    chk("restart_vld", gif.grp_vld, 1);
    chk("restart_stage", gif.grp_stage, 0);
    wait_novld(20);
    finish_cp();
    wait_idle(20);

    // Push and pop in the same cycle while full
    do_reset();
    gif.grp_ready = 1'b0;
    start_cp(24'($urandom));
    repeat (4) push_rand();
    b0 = beats;
    gif.grp_ready = 1'b1;
    tick(); tick();
    push_rand();
    chk("pp_ovf", overflow, 0);
    wait_novld(100);
    chk("pp_beats", beats - b0, 15);
    finish_cp();
    wait_idle(20);

    // Randomized runs
    ready_mode = 2;
    for (int r = 0; r < 12; r++) begin
      int n;
      if (r % 4 == 0) do_reset();
      start_cp(24'($urandom));
      n = $urandom_range(1, SN);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 4)) tick();
        push_rand();
      end
      finish_cp();
      wait_idle(300);
      tick();
    end
    ready_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/knn_group_gather.md
KNN_GROUP_GATHER -- requirements
Module: knn_group_gather

Interface
REQ-001 Parameter addr_W, default 24, packed point width {x,y,z}, each axis addr_W/3 bits unsigned.
REQ-002 Parameter stage_num, default 8, neighbour triplets per centre point.
REQ-003 Parameter FIFO_DEPTH, default 4, triplet buffer entries, power of two.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cp  input  addr_W  centre point, sampled together with cp_vld.
REQ-007 cp_vld  input  1  centre-point strobe, driven by the same source as the KNN stage CP input.
REQ-008 nb_0, nb_1, nb_2  input  addr_W each  nearest neighbours from the KNN stage, valid only while nb_flag=1.
REQ-009 nb_flag  input  1  one-cycle strobe marking one valid triplet.
REQ-010 cp_finish  input  1  one-cycle strobe after the last triplet of a centre point.
REQ-011 grp_data  output  3*(addr_W/3+1)  relative point {dx,dy,dz}, each axis two's complement.
REQ-012 grp_stage  output  clog2(stage_num)  stage index of the beat.
REQ-013 grp_k  output  2  neighbour index 0..2.
REQ-014 grp_last  output  1  final beat of the centre point.
REQ-015 grp_vld  output  1  beat valid.
REQ-016 grp_ready  input  1  downstream accepts the beat.
REQ-017 overflow  output  1  sticky flag: a triplet was dropped.
REQ-018 busy  output  1  high when state is not IDLE.

Function
REQ-019 The state machine SHALL have three states: IDLE, COLLECT and FLUSH.
REQ-020 IDLE->COLLECT on cp_vld; cp SHALL be latched into cp_reg in that cycle.
REQ-021 cp_vld in COLLECT or FLUSH SHALL be ignored; cp_reg SHALL hold.
REQ-022 COLLECT->FLUSH on cp_finish.
REQ-023 FLUSH->IDLE in the cycle the grp_last beat handshakes (grp_vld & grp_ready).
REQ-024 In COLLECT, nb_flag=1 SHALL push {nb_0, nb_1, nb_2, stage_cnt} into the FIFO if it is not full; stage_cnt SHALL then increment.
REQ-025 stage_cnt SHALL clear on IDLE->COLLECT and SHALL saturate at stage_num-1.
REQ-026 A push when full with no pop in the same cycle SHALL drop the triplet and set overflow; stage_cnt SHALL still increment.
REQ-027 A push and a pop in the same cycle when full SHALL both take effect; overflow SHALL stay unchanged.
REQ-028 The output SHALL serialise the head triplet as beats k=0,1,2.
REQ-029 The FIFO SHALL pop on the handshake of the k=2 beat.
REQ-030 grp_vld SHALL equal FIFO non-empty; output fields SHALL be combinational from the FIFO head and the k counter.
REQ-031 d_axis = {0,nb_axis} - {0,cp_axis}, width addr_W/3+1; range -255..+255 for the default widths.
REQ-032 grp_last=1 iff k=2, head stage = stage_num-1, and state = FLUSH or cp_finish is seen.
REQ-033 grp_vld, grp_data, grp_stage and grp_k SHALL hold stable while grp_vld=1 and grp_ready=0.
REQ-034 If cp_finish arrives with the FIFO empty (all triplets dropped), the block SHALL return to IDLE next cycle with no grp_last beat.
REQ-035 nb_flag in IDLE or FLUSH SHALL be ignored.

Reset
REQ-036 When rst=1 at a clock edge, the block SHALL enter IDLE and clear the FIFO pointers and count, k, stage_cnt, cp_reg, overflow and busy.
REQ-037 During reset, grp_vld SHALL be 0 and grp_data, grp_stage, grp_k and grp_last SHALL be 0.
REQ-038 Reset mid-operation SHALL discard all buffered triplets; no beat SHALL be emitted after reset until a new cp_vld.

Structure
REQ-039 A shared package SHALL hold: point width, axis width, delta width, the state encoding (IDLE=2'd0, COLLECT=2'd1, FLUSH=2'd2) and the K=3 constant.
REQ-040 One sub-module, triplet_fifo (synchronous, parameterised width and depth, full/empty/count), SHALL hold the buffer.
REQ-041 Serialiser, subtractor and FSM SHALL reside in knn_group_gather.

Verification
REQ-042 cp=0x0A141E, one nb_flag with nb_0=0x0B131E, nb_1=0x0A141E, nb_2=0x00FFFF, grp_ready=1 -> three beats: dx/dy/dz = (+1,-1,0), (0,0,0), (-10,+235,+225); grp_k = 0,1,2; grp_stage = 0.
REQ-043 Full 8-stage run with triplets 20 cycles apart, grp_ready=1 -> 24 beats; grp_stage 0..7; grp_last only on beat 24; busy falls the cycle after beat 24; overflow = 0.
REQ-044 grp_ready held 0 and 5 triplets pushed (FIFO_DEPTH=4) -> 5th dropped, overflow=1; after release, 12 beats with stages 0..3 in order.
REQ-045 Backpressure: grp_ready toggles every cycle -> beat fields stable while stalled; no beat lost or duplicated.
REQ-046 rst asserted 1 cycle while 2 triplets are buffered -> next cycle grp_vld=0 and busy=0; a new cp_vld restarts with grp_stage=0.
REQ-047 Push and pop in the same cycle with the FIFO full -> both take effect; overflow stays 0; beat order is preserved.
